// File: rtl/turn_controller_if.sv
// Button, timeout and status bundle between the chess-clock turn controller and its surroundings.
interface turn_controller_if #(
    parameter int MOVE_W = 8
);
    logic              btn_start;
    logic              btn_white;
    logic              btn_black;
    logic              timeout_white;
    logic              timeout_black;
    logic              flag_white;
    logic              flag_black;
    logic              turn;
    logic              game_over;
    logic              winner;
    logic [MOVE_W-1:0] move_count;

    modport master (
        output btn_start, btn_white, btn_black, timeout_white, timeout_black,
        input  flag_white, flag_black, turn, game_over, winner, move_count
    );

    modport slave (
        input  btn_start, btn_white, btn_black, timeout_white, timeout_black,
        output flag_white, flag_black, turn, game_over, winner, move_count
    );
endinterface

// File: rtl/turn_controller.sv
// Chess-clock turn controller: debounced start/move buttons drive a five-state game FSM
// whose registered outputs enable the two countdown timers.
module turn_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MOVE_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    turn_controller_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int NBTN  = 3;

    typedef enum logic [2:0] {
        IDLE,
        WHITE_RUN,
        BLACK_RUN,
        PAUSED,
        GAME_OVER
    } state_t;

    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  level;
    logic [NBTN-1:0]  level_d;
    logic [NBTN-1:0]  press;
    logic [CNT_W-1:0] db_cnt [NBTN];

    logic start_ev;
    logic white_ev;
    logic black_ev;

    state_t            state, state_n;
    logic              turn_q, turn_n;
    logic              winner_q, winner_n;
    logic [MOVE_W-1:0] moves_q, moves_n;
    logic              flag_white_q;
    logic              flag_black_q;
    logic              game_over_q;

    assign raw = {bus.btn_black, bus.btn_white, bus.btn_start};

    // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < NBTN; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press    = level & ~level_d;
    assign start_ev = press[0];
    assign white_ev = press[1];
    assign black_ev = press[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            turn_q       <= 1'b0;
            winner_q     <= 1'b0;
            moves_q      <= '0;
            flag_white_q <= 1'b0;
            flag_black_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state        <= state_n;
            turn_q       <= turn_n;
            winner_q     <= winner_n;
            moves_q      <= moves_n;
            flag_white_q <= (state_n == WHITE_RUN);
            flag_black_q <= (state_n == BLACK_RUN);
            game_over_q  <= (state_n == GAME_OVER);
        end
    end

    // Within a run state the if-chain order gives timeout over own move over start.
    always_comb begin
        state_n  = state;
        turn_n   = turn_q;
        winner_n = winner_q;
        moves_n  = moves_q;
        case (state)
            IDLE: begin
                turn_n = 1'b0;
                if (start_ev) begin
                    state_n = WHITE_RUN;
                end
            end
            WHITE_RUN: begin
                if (bus.timeout_white) begin
                    state_n  = GAME_OVER;
                    winner_n = 1'b1;
                end else if (white_ev) begin
                    state_n = BLACK_RUN;
                    turn_n  = 1'b1;
                    moves_n = moves_q + 1'b1;
                end else if (start_ev) begin
                    state_n = PAUSED;
                end
            end
            BLACK_RUN: begin
                if (bus.timeout_black) begin
                    state_n  = GAME_OVER;
                    winner_n = 1'b0;
                end else if (black_ev) begin
                    state_n = WHITE_RUN;
                    turn_n  = 1'b0;
                    moves_n = moves_q + 1'b1;
                end else if (start_ev) begin
                    state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (start_ev) begin
                    state_n = turn_q ? BLACK_RUN : WHITE_RUN;
                end
            end
            GAME_OVER: begin
                state_n = GAME_OVER;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.flag_white = flag_white_q;
    assign bus.flag_black = flag_black_q;
    assign bus.turn       = turn_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
    assign bus.move_count = moves_q;
endmodule

// File: tb/tb_turn_controller.sv
// Scenario bench for turn_controller with a 4-cycle debounce and a 2-bit move counter.
module tb_turn_controller;
    typedef logic [6:0] snap_t;

    logic  clk = 1'b0;
    logic  reset;
    int    tests_run = 0;
    int    tests_failed = 0;
    int    flag_clash = 0;
    snap_t exp_q[$];
    snap_t obs;
    snap_t exp;

    turn_controller_if #(.MOVE_W(2)) bus ();

    turn_controller #(
        .DEBOUNCE_CYCLES(4),
        .MOVE_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.flag_white === 1'b1 && bus.flag_black === 1'b1) begin
            flag_clash++;
        end
    end

    // Snapshot order: flag_white, flag_black, turn, game_over, winner, move_count[1:0].
    function automatic snap_t mk(input logic fw, input logic fb, input logic tn,
                                 input logic go, input logic wn, input logic [1:0] mc);
        return {fw, fb, tn, go, wn, mc};
    endfunction

    function automatic snap_t sample();
        return {bus.flag_white, bus.flag_black, bus.turn, bus.game_over, bus.winner, bus.move_count};
    endfunction

    task automatic await_front(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 || sample() === exp_q[0]) break;
            @(negedge clk);
        end
    endtask

    task automatic set_btn(input int which, input logic val);
        case (which)
            0: bus.btn_start = val;
            1: bus.btn_white = val;
            default: bus.btn_black = val;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0));
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL reset_state: got %b expected %b", obs, exp); end
    endtask

    task automatic test_start_event();
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        set_btn(0, 1'b1);
        repeat (10) @(negedge clk);
        await_front(40);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL start_event: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        repeat (10) @(negedge clk);
        set_btn(0, 1'b0);
        repeat (10) @(negedge clk);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL start_hold_single: got %b expected %b", obs, exp); end
    endtask

    task automatic test_white_move();
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        press(1, 3);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL white_glitch: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd1));
        press(1, 10);
        await_front(40);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL white_move: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd1));
        press(1, 10);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL white_in_black_run: got %b expected %b", obs, exp); end
    endtask

    task automatic test_pause_resume();
        exp_q.push_back(mk(0, 0, 1, 0, 0, 2'd1));
        press(0, 10);
        await_front(40);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL pause: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(0, 0, 1, 0, 0, 2'd1));
        bus.timeout_black = 1'b1;
        bus.timeout_white = 1'b1;
        press(2, 10);
        bus.timeout_black = 1'b0;
        bus.timeout_white = 1'b0;
        @(negedge clk);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL paused_ignores: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd1));
        press(0, 10);
        await_front(40);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL resume_black: got %b expected %b", obs, exp); end
    endtask

    task automatic test_move_wrap();
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd2));
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd3));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd1));
        for (int m = 0; m < 4; m++) begin
            press((m % 2 == 0) ? 2 : 1, 10);
            await_front(40);
            obs = sample(); exp = exp_q.pop_front(); tests_run++;
            if (obs !== exp) begin tests_failed++; $display("[TB] FAIL move_wrap_%0d: got %b expected %b", m, obs, exp); end
        end
    endtask

    task automatic test_timeout_priority();
        exp_q.push_back(mk(0, 0, 1, 1, 0, 2'd1));
        // Black's press event is seen by the FSM at the 7th rising edge after the raw edge (2 sync + 4 debounce + edge detect).
        bus.btn_black = 1'b1;
        repeat (6) @(negedge clk);
        bus.timeout_black = 1'b1;
        @(negedge clk);
        bus.timeout_black = 1'b0;
        repeat (4) @(negedge clk);
        bus.btn_black = 1'b0;
        repeat (10) @(negedge clk);
        await_front(40);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL timeout_over_move: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(0, 0, 1, 1, 0, 2'd1));
        press(0, 10);
        press(1, 10);
        press(2, 10);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL game_over_hold: got %b expected %b", obs, exp); end
    endtask

    task automatic test_white_timeout();
        do_reset();
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        press(0, 10);
        await_front(40);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL restart_white: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        bus.timeout_black = 1'b1;
        repeat (3) @(negedge clk);
        bus.timeout_black = 1'b0;
        @(negedge clk);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL other_timeout_ignored: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(0, 0, 0, 1, 1, 2'd0));
        bus.timeout_white = 1'b1;
        @(negedge clk);
        bus.timeout_white = 1'b0;
        await_front(5);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL white_timeout: got %b expected %b", obs, exp); end
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        press(0, 10);
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd1));
        press(1, 10);
        await_front(40);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL black_run_setup: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0));
        bus.btn_black = 1'b1;
        bus.btn_start = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL async_reset: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL idle_after_release: got %b expected %b", obs, exp); end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        repeat (20) @(negedge clk);
        await_front(40);
        obs = sample(); exp = exp_q.pop_front(); tests_run++;
        if (obs !== exp) begin tests_failed++; $display("[TB] FAIL held_start_one_event: got %b expected %b", obs, exp); end
        bus.btn_black = 1'b0;
        bus.btn_start = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset             = 1'b0;
        bus.btn_start     = 1'b0;
        bus.btn_white     = 1'b0;
        bus.btn_black     = 1'b0;
        bus.timeout_white = 1'b0;
        bus.timeout_black = 1'b0;

        test_reset();
        test_start_event();
        test_white_move();
        test_pause_resume();
        test_move_wrap();
        test_timeout_priority();
        test_white_timeout();
        test_reset_mid_debounce();

        tests_run++;
        if (flag_clash !== 0) begin
            tests_failed++;
            $display("[TB] FAIL flags_exclusive: got %0d overlapping cycles expected 0", flag_clash);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, consecutive cycles a synchronized button must disagree with its debounced level before that level flips (minimum 2).
REQ-002 Parameter: MOVE_W, default 8, width of the move counter.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_start  input  1  raw start/pause pushbutton, active-high, asynchronous to clk.
REQ-006 btn_white  input  1  raw white "move done" button, active-high, asynchronous.
REQ-007 btn_black  input  1  raw black "move done" button, active-high, asynchronous.
REQ-008 timeout_white  input  1  white timer reached 0:00, level, synchronous to clk.
REQ-009 timeout_black  input  1  black timer reached 0:00, level, synchronous to clk.
REQ-010 flag_white  output  1  run enable for white countdown timer (1 = counting).
REQ-011 flag_black  output  1  run enable for black countdown timer.
REQ-012 turn  output  1  side to move: 0 = white, 1 = black.
REQ-013 game_over  output  1  game finished by timeout.
REQ-014 winner  output  1  valid when game_over: 0 = white won, 1 = black won.
REQ-015 move_count  output  MOVE_W  completed moves since reset.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: counter clears whenever synchronized value equals debounced level, else increments; on DEBOUNCE_CYCLES consecutive disagreeing cycles the level takes the synchronized value and the counter clears.
REQ-017 A press event SHALL be a single-cycle pulse on each 0->1 transition of a debounced level; holding a button yields exactly one event.
REQ-018 FSM states: IDLE, WHITE_RUN, BLACK_RUN, PAUSED, GAME_OVER; all outputs SHALL be registered, changing on the clock edge that enters the new state.
REQ-019 IDLE: flags 0, turn 0; start event -> WHITE_RUN.
REQ-020 WHITE_RUN: flag_white 1, flag_black 0, turn 0; white event -> BLACK_RUN with move_count+1; start event -> PAUSED; timeout_white -> GAME_OVER, winner 1.
REQ-021 BLACK_RUN: flag_black 1, flag_white 0, turn 1; black event -> WHITE_RUN with move_count+1; start event -> PAUSED; timeout_black -> GAME_OVER, winner 0.
REQ-022 PAUSED: both flags 0, turn held; start event -> run state of side given by turn; move buttons and timeouts ignored.
REQ-023 GAME_OVER: both flags 0, game_over 1, winner and move_count held; all inputs ignored until reset.
REQ-024 Non-moving side's button and the non-running side's timeout SHALL be ignored in every state.
REQ-025 Simultaneous events in a run state, priority: timeout > own move event > start event; lower-priority events that cycle are discarded.
REQ-026 Both flags SHALL never be 1 in the same cycle.
REQ-027 move_count SHALL wrap from 2^MOVE_W-1 to 0.

Reset
REQ-028 reset low SHALL immediately force state IDLE, all outputs 0, move_count 0, synchronizers, debounced levels and debounce counters 0, regardless of operation in progress.
REQ-029 After reset release, a button already held high SHALL produce one press event once debounced.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, btn_start high 10 cycles -> one start event; flag_white 1, turn 0, move_count 0; holding further gives no second event.
REQ-031 From WHITE_RUN, btn_white 3-cycle glitch -> no change; btn_white held 10 cycles -> flag_black 1, flag_white 0, turn 1, move_count 1; btn_white while BLACK_RUN -> ignored.
REQ-032 Run state, start press -> both flags 0, turn held; second start press -> same side resumes; timeout during PAUSED -> ignored.
REQ-033 BLACK_RUN, timeout_black=1 in the same cycle as black event -> GAME_OVER, winner 0, move_count unchanged; later presses ignored.
REQ-034 With MOVE_W=2, 4 alternating moves -> move_count 1,2,3,0.
REQ-035 reset low mid-debounce during BLACK_RUN -> all outputs 0 asynchronously; after release, state IDLE.
